// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output-port arbiter.
// The optional burst limiter is enabled by defining NOC_ARB_BURST_LIMIT_EN.
package noc_arb_pkg;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_S = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   // Supports one-hot vectors up to 32 bits; callers zero-extend.
   function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++)
         if (oh[i]) idx = idx | 32'(i);
      return idx;
   endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Rotating priority encoder: the first set req bit at or above the one-hot
// start position wins, wrapping to the lowest set bit.
module noc_rr_pick #(
   parameter int N = 5
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] start,
   output logic [N-1:0] pick,
   output logic         found
);

   logic [N-1:0] hi_req;
   logic [N-1:0] cand;

   // start-1 is a mask of the positions below start
   assign hi_req = req & ~(start - N'(1));
   assign cand   = (|hi_req) ? hi_req : req;
   assign pick   = cand & (~cand + N'(1));
   assign found  = |req;

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with RTS/DCTS handshake to the downstream router.
// Define NOC_ARB_BURST_LIMIT_EN to force rotation after MAX_BURST grants to one owner.
module noc_rr_arbiter
   import noc_arb_pkg::*;
#(
   parameter int NUM_PORTS = 5,
   parameter int MAX_BURST = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PORTS-1:0]         req,
   input  logic                         dcts,
   output logic [NUM_PORTS-1:0]         grant,
   output logic [NUM_PORTS-1:0]         xbar_sel,
   output logic [$clog2(NUM_PORTS)-1:0] owner_idx,
   output logic                         owner_vld,
   output logic                         rts
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   arb_state_e           state, state_nxt;
   logic [NUM_PORTS-1:0] owner, owner_nxt;
   logic [NUM_PORTS-1:0] start, pick_req, pick;
   logic                 found, hold, xfer, rts_nxt, force_rot;

   assign hold = rts & ~dcts;
   assign xfer = rts & dcts;

`ifdef NOC_ARB_BURST_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   logic [CNT_W-1:0] burst_cnt;

   assign force_rot = xfer && (burst_cnt == CNT_W'(MAX_BURST - 1)) && |(req & ~owner);

   // Saturates at MAX_BURST-1 so a sole requester can be rotated out later
   always_ff @(posedge clk) begin
      if (rst)
         burst_cnt <= '0;
      else if (state_nxt == IDLE || owner_nxt != owner)
         burst_cnt <= '0;
      else if (xfer && burst_cnt != CNT_W'(MAX_BURST - 1))
         burst_cnt <= burst_cnt + CNT_W'(1);
   end
`else
   logic unused_burst;
   assign unused_burst = ^MAX_BURST;
   assign force_rot    = 1'b0;
`endif

   always_comb begin
      start    = NUM_PORTS'(1);
      pick_req = req;
      if (state == OWNED) begin
         if (force_rot) begin
            start    = {owner[NUM_PORTS-2:0], owner[NUM_PORTS-1]};
            pick_req = req & ~owner;
         end else begin
            start = owner;
         end
      end
   end

   noc_rr_pick #(.N(NUM_PORTS)) u_pick (
      .req   (pick_req),
      .start (start),
      .pick  (pick),
      .found (found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         rts   <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         rts   <= rts_nxt;
      end
   end

   // Owner is frozen for the whole handshake so the crossbar never switches mid-transfer
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      if (!hold) begin
         if (found) begin
            state_nxt = OWNED;
            owner_nxt = pick;
         end else begin
            state_nxt = IDLE;
            owner_nxt = '0;
         end
      end
      rts_nxt = (state == OWNED) && !xfer;
   end

   always_comb begin
      grant     = owner & {NUM_PORTS{xfer}};
      xbar_sel  = owner;
      owner_vld = (state == OWNED);
      owner_idx = IDX_W'(onehot_to_idx(32'(owner)));
   end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

- Parametrised round-robin output-port arbiter for the NoC router.
- Accepts NUM_PORTS input request lines and selects one owner.
- Drives the crossbar select and performs the RTS/DCTS two-phase handshake with the downstream router.
- Generalises the fixed 5-port arbiter with arbitrary port count, a binary owner index, and an optional burst limiter against starvation.

## Interface
- NUM_PORTS, 5: number of requesting input ports; ≥2. Index 0 = Local, 1 = N, 2 = E, 3 = W, 4 = S.
- MAX_BURST, 8: consecutive transfers one owner may take before forced rotation; ≥1. Used only with NOC_ARB_BURST_LIMIT_EN.
- IDX_W, derived: $clog2(NUM_PORTS); not overridable.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_PORTS  per-port request, level-sensitive.
- dcts  in  1  downstream clear-to-send.
- grant  out  NUM_PORTS  one-hot per-port transfer strobe, combinational.
- xbar_sel  out  NUM_PORTS  one-hot crossbar select; all-zero when idle.
- owner_idx  out  IDX_W  binary index of the current owner; 0 when idle.
- owner_vld  out  1  high when not idle.
- rts  out  1  request-to-send to downstream, registered.

## Operation
- State:
  - Encoding: IDLE, or OWNED with a one-hot owner register.
  - Reset: IDLE. rts=0, grant=0, xbar_sel=0, owner_idx=0, owner_vld=0, burst count 0.
- Hold condition: hold = rts & ~dcts.
  - While hold is true, the owner is frozen regardless of req.
  - Otherwise the owner is reloaded each cycle from the picker.
- Picker (rotating priority encoder):
  - From IDLE, search starts at index 0 (Local first).
  - From OWNED, search starts at the current owner, so the owner keeps priority while requesting, then wraps ascending.
  - If no req bit is set, the next state is IDLE.
- rts next value:
  - 0 if the state is IDLE.
  - 0 if rts & dcts (a transfer just completed).
  - Else 1.
- Transfer: grant[i] = rts & dcts & owner[i]. At most one grant bit is set. There is no grant in IDLE.
- xbar_sel = owner one-hot, and is valid one cycle before rts rises.
- Owner changes take effect only at edges where hold=0. The crossbar never switches mid-handshake.
- Dropping req while rts is high does not cancel the pending handshake. The transfer completes when dcts arrives.

## Timing
- Request to rts: req rises at cycle 0 in IDLE → OWNED at edge 1 → rts=1 at edge 2 → grant when dcts=1 in cycle 2.
- Throughput: at most one transfer per 2 cycles per arbiter, since rts drops for one cycle after each transfer.
- dcts low with rts high: rts and owner hold indefinitely.
- Simultaneous events:
  - A transfer edge may also change the owner.
  - New req bits seen on that edge participate in the pick.
- Reset mid-handshake: all outputs go to their reset values at the next edge, and any pending transfer is dropped.

## Configuration
- NOC_ARB_BURST_LIMIT_EN defined:
  - A burst counter of width $clog2(MAX_BURST+1) counts grants for the current owner. It clears on owner change or IDLE.
  - When a grant occurs with count == MAX_BURST-1 and any other req bit is set, the search starts at owner+1, excluding the current owner.
  - If only the owner requests, it keeps ownership and the count saturates.
- NOC_ARB_BURST_LIMIT_EN undefined: no counter. The owner keeps the port while it holds req, which gives unbounded bursts.

## Structure
- Shared package noc_arb_pkg:
  - Port index constants PORT_L/N/E/W/S.
  - arb_state_e enum (IDLE, OWNED).
  - Helper function onehot_to_idx.
- Sub-module noc_rr_pick: combinational rotating priority encoder.
  - Parameter N.
  - Inputs: req and a start-index one-hot.
  - Outputs: a one-hot pick and a found flag.
  - Instanced once.

## Test plan
- Reset: assert rst with req=5'b11111, dcts=1 → rts=0, grant=0, xbar_sel=0, owner_vld=0 on the following cycle.
- Single request: req=5'b00100 (E), dcts=1 → owner_idx=2 at edge 1, rts=1 at edge 2, grant=5'b00100 in cycle 2, rts=0 in cycle 3, repeating every 2 cycles.
- Rotation: owner N (1), req drops to 5'b11001 at a transfer → next owner W (3), not S or L; then W drops → S (4); then S drops → L (0).
- Backpressure: owner E, rts=1, dcts=0 for 10 cycles while req changes to 5'b00001 → owner_idx stays 2, rts stays 1, no grant; when dcts=1, grant=5'b00100, then owner moves to L.
- Burst limit (macro on, MAX_BURST=3): owner N, req=5'b00110 → exactly 3 N grants, then owner E. With req=5'b00010 only, N keeps ownership beyond 3 grants. With the macro off, N keeps ownership indefinitely under req=5'b00110.
- Idle return: all req drop at a transfer edge → owner_vld=0, xbar_sel=0, and rts stays 0 until a new req arrives.
